// File: rtl/fetch_dispatch_queue.sv
// Fetch-to-dispatch decoupling FIFO: first-word-fall-through head, valid/ready on both sides,
// single-cycle mispredict flush.
module fetch_dispatch_queue #(
   parameter int DEPTH  = 8,
   parameter int INSN_W = 32,
   parameter int PC_W   = 64
) (
   input  logic                     in_clk,
   input  logic                     in_rst,
   input  logic                     in_flush,
   input  logic                     in_fetch_valid,
   input  logic [INSN_W-1:0]        in_fetch_insnbits,
   input  logic [PC_W-1:0]          in_fetch_pc,
   input  logic [PC_W-1:0]          in_fetch_pred_pc,
   output logic                     out_fetch_ready,
   output logic                     out_dp_valid,
   output logic [INSN_W-1:0]        out_dp_insnbits,
   output logic [PC_W-1:0]          out_dp_pc,
   output logic [PC_W-1:0]          out_dp_pred_pc,
   input  logic                     in_dp_ready,
   output logic [$clog2(DEPTH):0]   out_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [INSN_W-1:0] insn_mem [DEPTH];
   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [PC_W-1:0]   pred_mem [DEPTH];

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             push, pop;

   // Ready looks only at the registered count, so a full queue refuses a push even
   // when dispatch pops in the same cycle.
   assign out_fetch_ready = (count != CNT_W'(DEPTH));
   assign out_dp_valid    = (count != '0);
   assign out_count       = count;

   assign push = in_fetch_valid & out_fetch_ready;
   assign pop  = out_dp_valid & in_dp_ready;

   assign out_dp_insnbits = insn_mem[head];
   assign out_dp_pc       = pc_mem[head];
   assign out_dp_pred_pc  = pred_mem[head];

   always_ff @(posedge in_clk) begin
      if (in_rst || in_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry storage carries no reset; only pointers and count define occupancy.
   always_ff @(posedge in_clk) begin
      if (push && !in_rst && !in_flush) begin
         insn_mem[tail] <= in_fetch_insnbits;
         pc_mem[tail]   <= in_fetch_pc;
         pred_mem[tail] <= in_fetch_pred_pc;
      end
   end

   a_count_bound : assert property (@(posedge in_clk) disable iff (in_rst)
      count <= CNT_W'(DEPTH));
   a_ptr_eq : assert property (@(posedge in_clk) disable iff (in_rst)
      (head == tail) |-> (count == '0 || count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_dispatch_queue.sv
// Directed bench for fetch_dispatch_queue: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fetch_dispatch_queue;
   localparam int DEPTH = 8;

   logic        in_clk = 1'b0;
   logic        in_rst, in_flush, in_fetch_valid, in_dp_ready;
   logic [31:0] in_fetch_insnbits;
   logic [63:0] in_fetch_pc, in_fetch_pred_pc;
   logic        out_fetch_ready, out_dp_valid;
   logic [31:0] out_dp_insnbits;
   logic [63:0] out_dp_pc, out_dp_pred_pc;
   logic [3:0]  out_count;

   fetch_dispatch_queue #(.DEPTH(DEPTH), .INSN_W(32), .PC_W(64)) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_flush(in_flush),
      .in_fetch_valid(in_fetch_valid), .in_fetch_insnbits(in_fetch_insnbits),
      .in_fetch_pc(in_fetch_pc), .in_fetch_pred_pc(in_fetch_pred_pc),
      .out_fetch_ready(out_fetch_ready), .out_dp_valid(out_dp_valid),
      .out_dp_insnbits(out_dp_insnbits), .out_dp_pc(out_dp_pc),
      .out_dp_pred_pc(out_dp_pred_pc), .in_dp_ready(in_dp_ready),
      .out_count(out_count)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      logic [31:0] insn;
      logic [63:0] pc;
      logic [63:0] pred;
   } entry_t;

   entry_t model[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   bit     chk_en = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] insn_of(input logic [63:0] pc);
      return pc[31:0] ^ 32'h13579BDF;
   endfunction

   // Reference: the queue contents follow the fetch/dispatch handshake rules directly.
   always @(posedge in_clk) begin
      bit can_pop, can_push;
      can_pop  = (model.size() != 0) && in_dp_ready;
      can_push = in_fetch_valid && (model.size() < DEPTH);
      if (in_rst || in_flush) model.delete();
      else begin
         if (can_pop) void'(model.pop_front());
         if (can_push) model.push_back('{in_fetch_insnbits, in_fetch_pc, in_fetch_pred_pc});
      end
   end

   always @(negedge in_clk) begin
      if (chk_en) begin
         check("m_count", 64'(out_count), 64'(model.size()));
         check("m_fetch_ready", 64'(out_fetch_ready), 64'(model.size() != DEPTH));
         check("m_dp_valid", 64'(out_dp_valid), 64'(model.size() != 0));
         if (model.size() != 0) begin
            check("m_dp_pc", out_dp_pc, model[0].pc);
            check("m_dp_insn", 64'(out_dp_insnbits), 64'(model[0].insn));
            check("m_dp_pred", out_dp_pred_pc, model[0].pred);
         end
      end
   end

   task automatic tick;
      @(posedge in_clk);
      @(negedge in_clk);
   endtask

   task automatic set_push(input logic v, input logic [63:0] pc);
      in_fetch_valid    = v;
      in_fetch_pc       = pc;
      in_fetch_insnbits = insn_of(pc);
      in_fetch_pred_pc  = pc + 64'h8;
   endtask

   task automatic fill(input int n, input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         set_push(1'b1, base + 64'(4 * i));
         tick;
      end
      set_push(1'b0, 64'h0);
   endtask

   task automatic drain_all;
      in_dp_ready = 1'b1;
      for (int i = 0; i < 2 * DEPTH && out_dp_valid; i++) tick;
      in_dp_ready = 1'b0;
      check("drain_empty", 64'(out_dp_valid), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      in_rst = 1'b1; in_flush = 1'b0; in_dp_ready = 1'b0;
      set_push(1'b0, 64'h0);
      tick; tick;
      in_rst = 1'b0;
      check("rst_count", 64'(out_count), 64'h0);
      check("rst_ready", 64'(out_fetch_ready), 64'h1);
      check("rst_valid", 64'(out_dp_valid), 64'h0);
      chk_en = 1'b1;

      // Three pushes with dispatch stalled
      fill(3, 64'h0);
      check("three_count", 64'(out_count), 64'h3);
      check("three_pc", out_dp_pc, 64'h0);
      check("three_valid", 64'(out_dp_valid), 64'h1);

      // Fill to full, drop a ninth push, drain in order
      fill(5, 64'hC);
      check("full_count", 64'(out_count), 64'h8);
      check("full_ready", 64'(out_fetch_ready), 64'h0);
      set_push(1'b1, 64'h20);
      tick;
      set_push(1'b0, 64'h0);
      check("drop_count", 64'(out_count), 64'h8);
      in_dp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_pc", out_dp_pc, 64'(4 * i));
         tick;
      end
      check("drained_valid", 64'(out_dp_valid), 64'h0);
      tick; tick;  // ready while empty must be a no-op
      in_dp_ready = 1'b0;
      check("idle_count", 64'(out_count), 64'h0);

      // Steady state push+pop across pointer wraps
      set_push(1'b1, 64'h200);
      tick;
      in_dp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_push(1'b1, 64'h204 + 64'(4 * i));
         check("steady_pc", out_dp_pc, 64'h200 + 64'(4 * i));
         check("steady_count", 64'(out_count), 64'h1);
         tick;
      end
      set_push(1'b0, 64'h0);
      tick;
      in_dp_ready = 1'b0;
      check("steady_end", 64'(out_count), 64'h0);

      // Flush with simultaneous push and pop
      fill(5, 64'h300);
      check("pre_flush", 64'(out_count), 64'h5);
      set_push(1'b1, 64'h500);
      in_dp_ready = 1'b1;
      in_flush = 1'b1;
      tick;
      in_flush = 1'b0; in_dp_ready = 1'b0;
      set_push(1'b0, 64'h0);
      check("flush_count", 64'(out_count), 64'h0);
      check("flush_valid", 64'(out_dp_valid), 64'h0);
      set_push(1'b1, 64'h100);
      tick;
      set_push(1'b0, 64'h0);
      check("post_flush_pc", out_dp_pc, 64'h100);
      check("post_flush_count", 64'(out_count), 64'h1);
      drain_all;

      // Push into empty: visible only after the edge
      set_push(1'b1, 64'h400);
      check("pre_edge_valid", 64'(out_dp_valid), 64'h0);
      tick;
      set_push(1'b0, 64'h0);
      check("post_edge_valid", 64'(out_dp_valid), 64'h1);
      check("post_edge_insn", 64'(out_dp_insnbits), 64'h13579FDF);
      check("post_edge_pred", out_dp_pred_pc, 64'h408);
      drain_all;

      // Full queue with push+pop: push refused, pop taken; then reset mid-stream
      fill(8, 64'h600);
      set_push(1'b1, 64'h700);
      in_dp_ready = 1'b1;
      tick;
      set_push(1'b0, 64'h0);
      check("full_pop_count", 64'(out_count), 64'h7);
      check("full_pop_pc", out_dp_pc, 64'h604);
      tick;
      in_dp_ready = 1'b0;
      check("six_count", 64'(out_count), 64'h6);
      set_push(1'b1, 64'h800);
      in_dp_ready = 1'b1;
      in_rst = 1'b1;
      tick;
      in_rst = 1'b0; in_dp_ready = 1'b0;
      set_push(1'b0, 64'h0);
      check("midrst_count", 64'(out_count), 64'h0);
      check("midrst_ready", 64'(out_fetch_ready), 64'h1);
      check("midrst_valid", 64'(out_dp_valid), 64'h0);
      tick;

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
